pipe_fetch_queue: RTL and testbench
===================================

# pipe_fetch_queue

Parametrised fetch stage for the JAM-1 pipeline, replacing the single-register stage 0 with a small prefetch queue. Each cycle it fetches one instruction byte from `MemData` into a FIFO when the bus and downstream allow. It increments the selected program-counter register with a one-hot strobe. It presents the oldest queued byte to stage 1 under a valid/advance handshake. The queue absorbs downstream stalls without losing fetch slots, supports branch flushes, and generalises the two-PC flip to N PC registers.

## Interface
Parameters:
- `DATA_W`, 8: instruction byte width.
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `NUM_PC`, 2: number of PC registers (≥1); `PCSEL_W = max(1, $clog2(NUM_PC))`.
- `NOP_OPCODE`, 0: value driven on `Pipe0Out` when the queue is empty; `DATA_W` bits.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `MemData`, in, `DATA_W`: memory read data for the byte addressed by the active PC; valid in any cycle where a fetch is issued.
- `BusRequest`, in, 1: another master owns the bus; no fetch this cycle.
- `FetchSuppress`, in, 1: downstream inhibits fetch this cycle.
- `PcSel`, in, `PCSEL_W`: index of the active PC register.
- `Flush`, in, 1: discard all queued bytes (taken branch or interrupt).
- `Advance`, in, 1: stage 1 consumes `Pipe0Out` this cycle.
- `Pipe0Out`, out, `DATA_W`: head-of-queue byte, or `NOP_OPCODE` when empty.
- `Pipe0Valid`, out, 1: queue non-empty.
- `IncPC`, out, `NUM_PC`: one-hot increment strobe for the active PC; all zero when no fetch is issued.
- `QueueLevel`, out, `$clog2(DEPTH+1)`: current entry count, 0..`DEPTH`.

## Operation
- State:
  - storage array `DEPTH`×`DATA_W`;
  - write pointer and read pointer, each `$clog2(DEPTH)` bits, wrapping modulo `DEPTH`;
  - count register, 0..`DEPTH`.
- `Pop = Advance & Pipe0Valid & ~Flush`. `Advance` while empty is ignored.
- `FetchEn = ~BusRequest & ~FetchSuppress & ~Flush & (PcSel < NUM_PC) & (count < DEPTH | Pop)`.
- `IncPC[PcSel] = FetchEn`, combinational; all other bits are 0. An out-of-range `PcSel` issues no fetch and drives `IncPC = 0`.
- Push: on an edge with `FetchEn`, `MemData` is written at the write pointer and the write pointer increments.
- Pop: on an edge with `Pop`, the read pointer increments.
- Count update: `count + FetchEn − Pop`.
- Full queue: a simultaneous push and pop is legal. Count stays at `DEPTH`, and the pop frees the slot that the push reuses.
- `Pipe0Out` is a combinational read of storage at the read pointer when count > 0, otherwise `NOP_OPCODE`.
- `Pipe0Valid = (count != 0)`. `QueueLevel = count`.
- `Flush` has priority over all other inputs. On the edge, count and both pointers go to 0. No push, no pop, `IncPC = 0` that cycle. Storage contents are don't-care.
- `BusRequest` and `FetchSuppress` only gate fetch. They never block `Pop`, so the queue drains while the bus is held.

## Timing
- Reset (`rst_n` low, asynchronous), for the duration of reset:
  - pointers and count are 0;
  - `Pipe0Valid = 0`, `Pipe0Out = NOP_OPCODE`, `QueueLevel = 0`;
  - `IncPC = 0`, forced regardless of the other inputs.
- Reset mid-operation discards all queued bytes. The first fetch can issue in the first cycle after release.
- Fetch-to-output latency is 1 cycle. A byte fetched in cycle N appears on `Pipe0Out` with `Pipe0Valid = 1` in cycle N+1 if the queue was empty. There is no same-cycle bypass.
- `IncPC` and `MemData` refer to the same cycle. The PC increments on the same edge that captures the byte.
- Throughput is one byte per cycle sustained with `Advance` held high.
- After `Flush` in cycle N, `Pipe0Valid = 0` in cycle N+1. A new-path fetch can issue in cycle N+1.

## Test plan
- Reset/basic:
  - Stimulus: release reset, hold `Advance = 0`, `PcSel = 0`, feed `MemData` 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive cycles.
  - Required: `IncPC = 2'b01` for 4 cycles, then 0; `QueueLevel` reaches 4; 0x55 is not captured; `Pipe0Out = 0x11`.
- Drain under bus hold:
  - Stimulus: full queue from the previous scenario, `BusRequest = 1`, `Advance = 1`.
  - Required: `Pipe0Out` shows 0x11, 0x22, 0x33, 0x44 on successive cycles, then `NOP_OPCODE` with `Pipe0Valid = 0`; `IncPC = 0` throughout.
- Full push+pop:
  - Stimulus: queue full, `Advance = 1`, fetch enabled with `MemData = 0xA5`.
  - Required: `QueueLevel` stays 4; 0xA5 emerges 4 pops later; pointer wrap causes no data loss.
- Flush priority:
  - Stimulus: level 3, assert `Flush` together with `Advance = 1` and fetch conditions true.
  - Required: `IncPC = 0` that cycle; next cycle `QueueLevel = 0` and `Pipe0Out = NOP_OPCODE`.
- PC select:
  - Stimulus: `NUM_PC = 3`; cycle through `PcSel` = 0, 1, 2, 3.
  - Required: `IncPC` = 3'b001, 3'b010, 3'b100, then 3'b000 with no capture for `PcSel = 3`.
- Async reset mid-stream:
  - Stimulus: level 2, pulse `rst_n` low between clock edges.
  - Required: outputs go to reset values immediately without waiting for a clock edge; the queue is empty after release.

Source files
------------

// File: rtl/pipe_fetch_queue_if.sv
// Fetch-queue port bundle: memory/control inputs toward the queue and the
// stage-1 handshake plus PC strobes back out.
interface pipe_fetch_queue_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned NUM_PC = 2
);
  localparam int unsigned PCSEL_W = (NUM_PC > 1) ? $clog2(NUM_PC) : 1;
  localparam int unsigned LEVEL_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0]  MemData;
  logic               BusRequest;
  logic               FetchSuppress;
  logic [PCSEL_W-1:0] PcSel;
  logic               Flush;
  logic               Advance;
  logic [DATA_W-1:0]  Pipe0Out;
  logic               Pipe0Valid;
  logic [NUM_PC-1:0]  IncPC;
  logic [LEVEL_W-1:0] QueueLevel;

  modport master (
    output MemData,
    output BusRequest,
    output FetchSuppress,
    output PcSel,
    output Flush,
    output Advance,
    input  Pipe0Out,
    input  Pipe0Valid,
    input  IncPC,
    input  QueueLevel
  );

  modport slave (
    input  MemData,
    input  BusRequest,
    input  FetchSuppress,
    input  PcSel,
    input  Flush,
    input  Advance,
    output Pipe0Out,
    output Pipe0Valid,
    output IncPC,
    output QueueLevel
  );
endinterface

// File: rtl/pipe_fetch_queue.sv
// Pipeline stage 0 prefetch queue: fetches one byte per cycle into a small
// FIFO, strobes the active PC, and hands the oldest byte to stage 1.
module pipe_fetch_queue #(
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       DEPTH      = 4,
  parameter int unsigned       NUM_PC     = 2,
  parameter logic [DATA_W-1:0] NOP_OPCODE = '0
) (
  input logic               clk,
  input logic               rst_n,
  pipe_fetch_queue_if.slave q
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic not_empty;
  logic pc_in_range;
  logic has_room;
  logic pop;
  logic fetch_en;

  assign not_empty   = (count_q != '0);
  assign pc_in_range = (32'(q.PcSel) < NUM_PC);
  assign has_room    = (32'(count_q) < DEPTH);
  assign pop         = q.Advance & not_empty & ~q.Flush;

  // rst_n term keeps IncPC quiet for the whole reset, whatever the inputs do.
  assign fetch_en = rst_n & ~q.BusRequest & ~q.FetchSuppress & ~q.Flush & pc_in_range &
                    (has_room | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q.Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (fetch_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      // Push and pop together leave the level unchanged, including when full.
      if (fetch_en && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (!fetch_en && pop) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read once count covers it.
  always_ff @(posedge clk) begin
    if (fetch_en) mem_q[wr_ptr_q] <= q.MemData;
  end

  always_comb begin
    q.IncPC = '0;
    for (int unsigned i = 0; i < NUM_PC; i++) begin
      q.IncPC[i] = fetch_en & (32'(q.PcSel) == i);
    end
  end

  assign q.Pipe0Out   = not_empty ? mem_q[rd_ptr_q] : NOP_OPCODE;
  assign q.Pipe0Valid = not_empty;
  assign q.QueueLevel = count_q;
endmodule

// File: tb/tb_pipe_fetch_queue.sv
// Directed vector bench for pipe_fetch_queue (DEPTH 4, three PC registers).
module tb_pipe_fetch_queue;
  localparam int unsigned DW  = 8;
  localparam int unsigned DP  = 4;
  localparam int unsigned NPC = 3;
  localparam logic [7:0]  NOP = 8'hEA;

  typedef struct {
    logic       flush;
    logic       adv;
    logic       breq;
    logic       supp;
    logic [1:0] sel;
    logic [7:0] data;
    logic [2:0] inc;
    logic [2:0] lvl;
    logic       vld;
    logic [7:0] out;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  pipe_fetch_queue_if #(.DATA_W(DW), .DEPTH(DP), .NUM_PC(NPC)) bus ();

  pipe_fetch_queue #(
    .DATA_W    (DW),
    .DEPTH     (DP),
    .NUM_PC    (NPC),
    .NOP_OPCODE(NOP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .q    (bus.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic f, input logic a, input logic b, input logic s,
                              input logic [1:0] sel, input logic [7:0] d, input logic [2:0] inc,
                              input logic [2:0] lvl, input logic vld, input logic [7:0] out);
    vec_t v;
    v = '{f, a, b, s, sel, d, inc, lvl, vld, out};
    vq.push_back(v);
  endfunction

  task automatic drive(input vec_t v);
    bus.Flush         = v.flush;
    bus.Advance       = v.adv;
    bus.BusRequest    = v.breq;
    bus.FetchSuppress = v.supp;
    bus.PcSel         = v.sel;
    bus.MemData       = v.data;
  endtask

  task automatic chk_outs(input string tag, input logic [2:0] inc, input logic [2:0] lvl,
                          input logic vld, input logic [7:0] out);
    chk({tag, " inc"}, 32'(bus.IncPC), 32'(inc));
    chk({tag, " lvl"}, 32'(bus.QueueLevel), 32'(lvl));
    chk({tag, " vld"}, 32'(bus.Pipe0Valid), 32'(vld));
    chk({tag, " out"}, 32'(bus.Pipe0Out), 32'(out));
  endtask

  initial begin
    // Expected columns describe outputs before the edge that applies the inputs.
    //   f  a  b  s  sel  data   inc     lvl vld out
    // Fill: only four of five bytes are captured.
    add(0, 0, 0, 0, 0, 8'h11, 3'b001, 0, 0, NOP);
    add(0, 0, 0, 0, 0, 8'h22, 3'b001, 1, 1, 8'h11);
    add(0, 0, 0, 0, 0, 8'h33, 3'b001, 2, 1, 8'h11);
    add(0, 0, 0, 0, 0, 8'h44, 3'b001, 3, 1, 8'h11);
    add(0, 0, 0, 0, 0, 8'h55, 3'b000, 4, 1, 8'h11);
    // Drain while the bus is held; advance on empty is ignored.
    add(0, 1, 1, 0, 0, 8'h00, 3'b000, 4, 1, 8'h11);
    add(0, 1, 1, 0, 0, 8'h00, 3'b000, 3, 1, 8'h22);
    add(0, 1, 1, 0, 0, 8'h00, 3'b000, 2, 1, 8'h33);
    add(0, 1, 1, 0, 0, 8'h00, 3'b000, 1, 1, 8'h44);
    add(0, 1, 1, 0, 0, 8'h00, 3'b000, 0, 0, NOP);
    // Refill, then push and pop together while full.
    add(0, 0, 0, 0, 0, 8'h61, 3'b001, 0, 0, NOP);
    add(0, 0, 0, 0, 0, 8'h62, 3'b001, 1, 1, 8'h61);
    add(0, 0, 0, 0, 0, 8'h63, 3'b001, 2, 1, 8'h61);
    add(0, 0, 0, 0, 0, 8'h64, 3'b001, 3, 1, 8'h61);
    add(0, 1, 0, 0, 0, 8'hA5, 3'b001, 4, 1, 8'h61);
    add(0, 1, 1, 0, 0, 8'h00, 3'b000, 4, 1, 8'h62);
    add(0, 1, 1, 0, 0, 8'h00, 3'b000, 3, 1, 8'h63);
    add(0, 1, 1, 0, 0, 8'h00, 3'b000, 2, 1, 8'h64);
    add(0, 1, 1, 0, 0, 8'h00, 3'b000, 1, 1, 8'hA5);
    // Build level 3, flush with advance and fetch conditions true.
    add(0, 0, 0, 0, 0, 8'h71, 3'b001, 0, 0, NOP);
    add(0, 0, 0, 0, 0, 8'h72, 3'b001, 1, 1, 8'h71);
    add(0, 0, 0, 0, 0, 8'h73, 3'b001, 2, 1, 8'h71);
    add(1, 1, 0, 0, 0, 8'h74, 3'b000, 3, 1, 8'h71);
    add(0, 0, 0, 0, 0, 8'h81, 3'b001, 0, 0, NOP);
    // PC select sweep, including an out-of-range index.
    add(0, 1, 0, 0, 1, 8'h82, 3'b010, 1, 1, 8'h81);
    add(0, 0, 0, 0, 2, 8'h83, 3'b100, 1, 1, 8'h82);
    add(0, 0, 0, 0, 3, 8'h84, 3'b000, 2, 1, 8'h82);
    add(0, 0, 0, 0, 0, 8'h85, 3'b001, 2, 1, 8'h82);
    // Suppressed fetch still pops; 0x84 must never appear.
    add(0, 1, 0, 1, 0, 8'h86, 3'b000, 3, 1, 8'h82);
    add(0, 1, 0, 0, 0, 8'h87, 3'b001, 2, 1, 8'h83);
    add(0, 1, 1, 0, 0, 8'h00, 3'b000, 2, 1, 8'h85);
    add(0, 1, 1, 0, 0, 8'h00, 3'b000, 1, 1, 8'h87);
    add(0, 0, 0, 0, 0, 8'h91, 3'b001, 0, 0, NOP);
    add(0, 0, 0, 0, 0, 8'h92, 3'b001, 1, 1, 8'h91);

    // Reset with fetch-enabling inputs: IncPC must stay low.
    drive('{0, 1, 0, 0, 0, 8'h99, 0, 0, 0, 0});
    #12;
    chk_outs("reset", 3'b000, 0, 0, NOP);
    @(negedge clk);
    chk_outs("reset_hold", 3'b000, 0, 0, NOP);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      #2;
      chk_outs($sformatf("v%0d", i), vq[i].inc, vq[i].lvl, vq[i].vld, vq[i].out);
      @(negedge clk);
    end

    // Asynchronous reset between edges with level 2.
    drive('{0, 0, 0, 0, 0, 8'h93, 0, 0, 0, 0});
    #2;
    chk("pre_arst lvl", 32'(bus.QueueLevel), 32'd2);
    rst_n = 1'b0;
    #1;
    chk_outs("arst", 3'b000, 0, 0, NOP);
    @(posedge clk);
    #1;
    chk_outs("arst_edge", 3'b000, 0, 0, NOP);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk_outs("post_arst", 3'b001, 0, 0, NOP);
    @(posedge clk);
    #1;
    chk_outs("post_arst_fetch", 3'b001, 1, 1, 8'h93);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
